// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides, a registered result,
// and logical shifts performed iteratively at one bit per cycle.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_NAND = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_XOR  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic             shift_left;

    logic [WIDTH-1:0] op_res;
    logic             op_ovf;
    logic             op_ill;
    logic             op_is_shift;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] acc_next;
    logic             accept;

    assign shamt    = b[SHW-1:0];
    assign b_eff    = (aluctl == OP_SUB) ? (~b + 1'b1) : b;
    assign sum      = a + b_eff;
    assign acc_next = shift_left ? (acc << 1) : (acc >> 1);

    // HOLD can hand its result off and take a new request on the same edge.
    assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;
    assign zero     = (result == '0);

    // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        op_res      = '0;
        op_ovf      = 1'b0;
        op_ill      = 1'b0;
        op_is_shift = 1'b0;
        unique case (aluctl)
            OP_AND:  op_res = a & b;
            OP_OR:   op_res = a | b;
            OP_ADD, OP_SUB: begin
                op_res = sum;
                op_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL: begin
                op_res      = a;
                op_is_shift = 1'b1;
            end
            OP_SRL: begin
                op_res      = a;
                op_is_shift = 1'b1;
            end
            OP_NAND: op_res = ~(a & b);
            OP_NOR:  op_res = ~(a | b);
            OP_XOR:  op_res = a ^ b;
            default: op_ill = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc        <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            illegal    <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        if (op_is_shift && (shamt != '0)) begin
                            state      <= ST_SHIFT;
                            out_valid  <= 1'b0;
                            acc        <= a;
                            cnt        <= shamt;
                            shift_left <= (aluctl == OP_SLL);
                        end else begin
                            state     <= ST_HOLD;
                            out_valid <= 1'b1;
                            result    <= op_res;
                            overflow  <= op_ovf;
                            illegal   <= op_ill;
                        end
                    end else if ((state == ST_HOLD) && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    // The final step writes straight to result, so latency is exactly k edges.
                    if (cnt == SHW'(1)) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        result    <= acc_next;
                        overflow  <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a reference model feeds a scoreboard queue at
// acceptance and each completed handshake is compared against the queue head.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ovf;
        logic             ill;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t pending;

    alu_exec_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluctl    (aluctl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] c, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t             e;
        logic [WIDTH-1:0] yn;
        e  = '0;
        yn = ~y + 1;
        case (c)
            4'd0:  e.res = x & y;
            4'd1:  e.res = x | y;
            4'd2: begin
                e.res = x + y;
                e.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (e.res[WIDTH-1] != x[WIDTH-1]);
            end
            4'd3:  e.res = x << y[SHW-1:0];
            4'd4:  e.res = x >> y[SHW-1:0];
            4'd6: begin
                e.res = x - y;
                e.ovf = (x[WIDTH-1] == yn[WIDTH-1]) && (e.res[WIDTH-1] != x[WIDTH-1]);
            end
            4'd7:  e.res = ~(x & y);
            4'd12: e.res = ~(x | y);
            4'd13: e.res = x ^ y;
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        in_valid = 1'b1;
        aluctl   = c;
        a        = x;
        b        = y;
        pending  = model(c, x, y);
    endtask

    // One clock: on the negedge, score a completing output and queue an accepted
    // request; inputs are updated 1 time unit after the posedge.
    task automatic tick();
        bit   took;
        exp_t e;
        took = 0;
        @(negedge clk);
        if (out_valid && out_ready) begin
            check("sb_nonempty", WIDTH'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("zero", zero, e.zero);
                check("overflow", overflow, e.ovf);
                check("illegal", illegal, e.ill);
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back(pending);
            took = 1;
        end
        @(posedge clk);
        #1;
        if (took) in_valid = 1'b0;
    endtask

    task automatic run_single(input logic [3:0] c, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        drive(c, x, y);
        tick();
        check("single_latency", out_valid, 1);
        tick();
    endtask

    initial begin
        int   n;
        logic stale;
        exp_t held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluctl    = '0;
        a         = '0;
        b         = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_overflow", overflow, 0);
        check("rst_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Single-cycle ops, including add/sub overflow corners and the illegal code.
        run_single(4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        run_single(4'd6, 32'h1234_5678, 32'h1234_5678);
        run_single(4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run_single(4'd12, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run_single(4'd13, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run_single(4'd0, 32'hDEAD_BEEF, 32'h0F0F_F0F0);
        run_single(4'd1, 32'h1200_0034, 32'h0056_7800);
        run_single(4'd6, 32'h8000_0000, 32'h0000_0001);
        run_single(4'd6, 32'h0000_0000, 32'h8000_0000);
        run_single(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_single(4'd15, 32'h1234_5678, 32'h0000_0001);
        run_single(4'd3, 32'hCAFE_0001, 32'hFFFF_FFE0);

        // sll by 5: busy for edges N+1..N+4, result after edge N+5.
        drive(4'd3, 32'h0000_0001, 32'd5);
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("shift_in_ready", in_ready, 0);
            check("shift_out_valid", out_valid, 0);
        end
        tick();
        check("shift5_out_valid", out_valid, 1);
        check("shift5_result", result, 32'h0000_0020);
        tick();

        // srl by 31 with upper bits of b set (ignored).
        drive(4'd4, 32'h8000_0000, 32'hFFFF_FF1F);
        tick();
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("srl31_latency", n, 31);
        tick();

        // Backpressure for 4 cycles, then back-to-back acceptance.
        out_ready = 1'b0;
        drive(4'd2, 32'h8000_0000, 32'h8000_0000);
        held = pending;
        tick();
        check("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_stable_result", result, held.res);
            check("bp_stable_ovf", overflow, held.ovf);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid_hold", out_valid, 1);
        end
        out_ready = 1'b1;
        drive(4'd13, 32'hAAAA_5555, 32'h0F0F_0F0F);
        #1;
        check("b2b_in_ready", in_ready, 1);
        tick();
        check("b2b_out_valid", out_valid, 1);
        check("b2b_new_result", result, 32'hA5A5_5A5A);
        tick();

        // Full-throughput stream of single-cycle ops.
        drive(4'd2, 32'd10, 32'd20);
        tick();
        drive(4'd6, 32'd5, 32'd7);
        tick();
        check("tp_in_ready", in_ready, 1);
        drive(4'd1, 32'h0000_FF00, 32'h00FF_0000);
        tick();
        check("tp_out_valid", out_valid, 1);
        tick();
        check("tp_drained", out_valid, 0);

        // Reset mid-shift discards the operation.
        drive(4'd3, 32'h0000_0001, 32'd20);
        for (int i = 0; i < 7; i++) tick();
        check("mid_shift_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_result", result, 0);
        check("mrst_zero", zero, 1);
        check("mrst_overflow", overflow, 0);
        check("mrst_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid || !in_ready) stale = 1'b1;
        end
        check("post_rst_no_stale", stale, 0);

        // A fresh op after reset still works.
        run_single(4'd2, 32'hFFFF_FFFF, 32'h0000_0001);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
